serial_link_arbiter: RTL and testbench

//  Shares one sendFrame serial transmitter between N_REQ requesters, each offering a FRAME_WORDS-word frame.

---
 rtl/serial_link_arbiter_pkg.sv | 30 +++
 rtl/serial_link_arbiter_rr_pick.sv | 46 ++++
 rtl/serial_link_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_serial_link_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_arbiter_pkg
// Shared definitions for the serial link arbiter and its round-robin picker:
//   - arb_state_e : FSM state encodings (ST_IDLE / ST_START / ST_BUSY / ST_DONE)
//   - DEF_WIDTH / DEF_FRAME_WORDS : default word width and frame length
//   - rr_wrap / rr_next : modulo helpers used for round-robin pointer arithmetic
// -----------------------------------------------------------------------------
package serial_link_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_FRAME_WORDS = 2;

    // Fold a value in [0, 2n) back into [0, n).
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

    // Requester index that follows idx in round-robin order.
    function automatic int rr_next(input int idx, input int n);
        return rr_wrap(idx + 1, n);
    endfunction

endpackage

// File: rtl/serial_link_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker: selects the first set request bit at
// or after rr_ptr, wrapping modulo N.
// Ports:
//   req        in  [N-1:0]   pending requests
//   rr_ptr     in  [PW-1:0]  highest-priority index for this pick
//   winner     out [N-1:0]   one-hot winner (all zero when req == 0)
//   winner_idx out [PW-1:0]  binary index of the winner (0 when req == 0)
//   any        out           at least one request pending
// -----------------------------------------------------------------------------
module rr_pick
    import serial_link_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] winner_idx,
    output logic          any
);

    // Scan from rr_ptr upward; the first hit locks the result.
    always_comb begin
        int  j;
        logic found;
        j          = 0;
        found      = 1'b0;
        winner     = '0;
        winner_idx = '0;
        for (int k = 0; k < N; k++) begin
            j = rr_wrap(int'(rr_ptr) + k, N);
            if (!found && req[j]) begin
                found      = 1'b1;
                winner[j]  = 1'b1;
                winner_idx = PW'(j);
            end else begin
                found = found;
            end
        end
        any = found;
    end

endmodule

// File: rtl/serial_link_arbiter.sv
// -----------------------------------------------------------------------------
// serial_link_arbiter
// Shares one serial frame transmitter between N_REQ requesters, one frame at a
// time, with round-robin fairness. Lives in the transmitter clock domain.
// Optional feature macro: SERIAL_ARB_TIMEOUT_EN (BUSY watchdog + timeout_err).
// Ports:
//   clock           in   transmitter clock, all state on posedge
//   reset           in   asynchronous, active-high
//   req             in   [N_REQ]  requester i has a frame pending
//   req_data        in   word k of requester i at [(i*FRAME_WORDS+k)*WIDTH +: WIDTH]
//   grant           out  [N_REQ]  one-hot requester being served
//   done            out  [N_REQ]  one-cycle pulse when the served frame is out
//   busy            out  high in every state except IDLE
//   link_start      out  one-cycle start pulse to the transmitter
//   link_word       out  [WIDTH]  word link_index of the granted requester
//   link_index      in   [IDX_W]  word the transmitter is currently sending
//   link_ready_next in   transmitter frame ends after this cycle
//   timeout_err     out  sticky watchdog flag (SERIAL_ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module serial_link_arbiter
    import serial_link_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int IDX_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
`ifdef SERIAL_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 64
`endif
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_REQ-1:0]                   req,
    input  logic [N_REQ*FRAME_WORDS*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]                   grant,
    output logic [N_REQ-1:0]                   done,
    output logic                               busy,
    output logic                               link_start,
    output logic [WIDTH-1:0]                   link_word,
    input  logic [IDX_W-1:0]                   link_index,
    input  logic                               link_ready_next
`ifdef SERIAL_ARB_TIMEOUT_EN
    ,
    output logic                               timeout_err
`endif
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] gidx_q, gidx_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic             link_start_q, link_start_d;
    logic             wd_expire_s;

    logic [N_REQ-1:0] pick_winner_s;
    logic [PTR_W-1:0] pick_idx_s;
    logic             pick_any_s;

    rr_pick #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .winner     (pick_winner_s),
        .winner_idx (pick_idx_s),
        .any        (pick_any_s)
    );

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // Watchdog: count BUSY cycles; expiry only matters if the frame has not ended.
    always_comb begin
        wd_cnt_d      = '0;
        wd_expire_s   = 1'b0;
        timeout_err_d = timeout_err_q;
        if (state_q == ST_BUSY) begin
            wd_cnt_d    = wd_cnt_q + CNT_W'(1);
            wd_expire_s = !link_ready_next && (wd_cnt_q == CNT_W'(TIMEOUT - 1));
        end else begin
            wd_cnt_d    = '0;
            wd_expire_s = 1'b0;
        end
        if (wd_expire_s) begin
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // Watchdog registers; the error flag is sticky until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wd_expire_s = 1'b0;
`endif

    // Next-state logic. grant, done, busy and link_start are all computed one
    // cycle ahead so the outputs come straight from flops.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        done_d   = '0;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d = ST_START;
                    grant_d = pick_winner_s;
                    gidx_d  = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // Leaving BUSY releases the grant and moves priority past the winner.
                if (link_ready_next || wd_expire_s) begin
                    state_d  = ST_DONE;
                    grant_d  = '0;
                    done_d   = grant_q;
                    rr_ptr_d = PTR_W'(rr_next(int'(gidx_q), N_REQ));
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                // Requests are not looked at here; arbitration resumes in IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d       = (state_d != ST_IDLE);
        link_start_d = (state_d == ST_START);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            done_q       <= '0;
            rr_ptr_q     <= '0;
            busy_q       <= 1'b0;
            link_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            done_q       <= done_d;
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
            link_start_q <= link_start_d;
        end
    end

    // Word mux follows the transmitter index combinationally; out-of-range
    // indices and the ungranted case both yield zero.
    always_comb begin
        link_word = '0;
        if ((grant_q != '0) && (int'(link_index) < FRAME_WORDS)) begin
            link_word = req_data[(int'(gidx_q) * FRAME_WORDS + int'(link_index)) * WIDTH +: WIDTH];
        end else begin
            link_word = '0;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign link_start = link_start_q;

endmodule

// File: tb/tb_serial_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_link_arbiter
// Directed bench for serial_link_arbiter with a behavioural frame transmitter
// (BITS cycles per word, word 0 first). Expected (done vector, frame) pairs are
// queued when a request is driven and compared when done pulses.
// Frame value F maps to word0 = F[15:8], word1 = F[7:0].
// -----------------------------------------------------------------------------
module tb_serial_link_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int FW   = 2;
    localparam int BITS = 3;

    typedef struct packed {
        logic [N-1:0]  done_v;
        logic [15:0]   frame;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0]       req = '0;
    logic [N*FW*W-1:0]  req_data = '0;
    logic [N-1:0]       grant;
    logic [N-1:0]       done;
    logic               busy;
    logic               link_start;
    logic [W-1:0]       link_word;
    logic [0:0]         link_index;
    logic               link_ready_next;
`ifdef SERIAL_ARB_TIMEOUT_EN
    logic               timeout_err;
`endif

    // Transmitter model state
    logic               tx_stall = 1'b0;
    logic               tx_active;
    logic [0:0]         tx_idx;
    logic [7:0]         tx_cnt;
    logic [7:0]         rx_acc;
    logic [15:0]        rx_frame;
    int                 start_cnt;

    exp_t               exp_q[$];
    int                 passed = 0;
    int                 total  = 0;

    serial_link_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .req_data        (req_data),
        .grant           (grant),
        .done            (done),
        .busy            (busy),
        .link_start      (link_start),
        .link_word       (link_word),
        .link_index      (link_index),
        .link_ready_next (link_ready_next)
`ifdef SERIAL_ARB_TIMEOUT_EN
        ,
        .timeout_err     (timeout_err)
`endif
    );

    always #5 clock = ~clock;

    assign link_index      = tx_idx;
    assign link_ready_next = tx_active && (tx_idx == 1'b1) && (tx_cnt == 8'(BITS - 1));

    // Behavioural transmitter: latches link_word at the last cycle of each word.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_active <= 1'b0;
            tx_idx    <= 1'b0;
            tx_cnt    <= 8'd0;
            rx_acc    <= 8'd0;
            rx_frame  <= 16'd0;
            start_cnt <= 0;
        end else begin
            if (link_start) start_cnt <= start_cnt + 1;
            if (!tx_active) begin
                if (link_start && !tx_stall) begin
                    tx_active <= 1'b1;
                    tx_idx    <= 1'b0;
                    tx_cnt    <= 8'd0;
                end
            end else if (tx_cnt == 8'(BITS - 1)) begin
                tx_cnt <= 8'd0;
                rx_acc <= link_word;
                if (tx_idx == 1'b1) begin
                    tx_active <= 1'b0;
                    tx_idx    <= 1'b0;
                    rx_frame  <= {rx_acc, link_word};
                end else begin
                    tx_idx <= 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 8'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_frame(input int i, input logic [15:0] f);
        req_data[(i*FW+0)*W +: W] = f[15:8];
        req_data[(i*FW+1)*W +: W] = f[7:0];
    endtask

    task automatic expect_frame(input int i, input logic [15:0] f);
        exp_t e;
        e.done_v = N'(1) << i;
        e.frame  = f;
        exp_q.push_back(e);
    endtask

    // Wait for a done pulse, pop the scoreboard and compare; then confirm the
    // pulse lasts one cycle. If drop_req, req is cleared while done is seen.
    task automatic wait_done(input string tag, input bit drop_req);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            if (done != '0) got = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_done_vec"}, 64'(done), 64'(e.done_v));
            check({tag, "_rx_frame"}, 64'(rx_frame), 64'(e.frame));
            check({tag, "_grant_clr"}, 64'(grant), 64'd0);
        end
        if (drop_req) req = '0;
        @(negedge clock);
        check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    endtask

    task automatic wait_start(input string tag);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clock);
            if (link_start) got = 1'b1;
        end
        check({tag, "_start_seen"}, 64'(got), 64'd1);
    endtask

    initial begin
        int s0;
        int n;
        bit got;

        // ---- reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(link_start), 64'd0);
        check("rst_word", 64'(link_word), 64'd0);
`ifdef SERIAL_ARB_TIMEOUT_EN
        check("rst_terr", 64'(timeout_err), 64'd0);
`endif

        // ---- 1: single frame, grant one cycle after req
        set_frame(2, 16'h76A5);
        s0 = start_cnt;
        req = 4'b0100;
        expect_frame(2, 16'h76A5);
        @(negedge clock);
        check("t1_grant", 64'(grant), 64'h4);
        check("t1_start", 64'(link_start), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        req = 4'b0000;
        @(negedge clock);
        check("t1_start_1cyc", 64'(link_start), 64'd0);
        check("t1_grant_hold", 64'(grant), 64'h4);
        wait_done("t1", 1'b0);
        check("t1_busy_drop", 64'(busy), 64'd0);
        check("t1_nstarts", 64'(start_cnt - s0), 64'd1);

        // ---- 2: round-robin with all requesters pending (rr_ptr now 3)
        set_frame(0, 16'h1111);
        set_frame(1, 16'h2222);
        set_frame(2, 16'h3333);
        set_frame(3, 16'h4444);
        req = 4'b1111;
        expect_frame(3, 16'h4444);
        expect_frame(0, 16'h1111);
        expect_frame(1, 16'h2222);
        expect_frame(2, 16'h3333);
        expect_frame(3, 16'h4444);
        wait_done("t2a", 1'b0);
        wait_done("t2b", 1'b0);
        wait_done("t2c", 1'b0);
        wait_done("t2d", 1'b0);
        wait_done("t2e", 1'b1);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // ---- 3: pointer wrap (rr_ptr now 0): serve 1, then req 0011 -> 0 before 1
        req = 4'b0010;
        expect_frame(1, 16'h2222);
        wait_done("t3a", 1'b1);
        req = 4'b0011;
        expect_frame(0, 16'h1111);
        expect_frame(1, 16'h2222);
        wait_done("t3b", 1'b0);
        wait_done("t3c", 1'b1);
        // serve 3, then req 1001 -> 0 before 3
        req = 4'b1000;
        expect_frame(3, 16'h4444);
        wait_done("t3d", 1'b1);
        req = 4'b1001;
        expect_frame(0, 16'h1111);
        expect_frame(3, 16'h4444);
        wait_done("t3e", 1'b0);
        wait_done("t3f", 1'b1);

        // ---- 4: reset mid-frame, then a full frame afterwards
        set_frame(0, 16'hA5A5);
        req = 4'b0001;
        wait_start("t4");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("t4_rst_grant", 64'(grant), 64'd0);
        check("t4_rst_busy", 64'(busy), 64'd0);
        check("t4_rst_word", 64'(link_word), 64'd0);
        check("t4_rst_start", 64'(link_start), 64'd0);
        @(negedge clock);
        set_frame(0, 16'h5A5A);
        reset = 1'b0;
        expect_frame(0, 16'h5A5A);
        wait_done("t4", 1'b1);

        // ---- 5: request dropped mid-frame still completes once
        set_frame(1, 16'hC3E7);
        req = 4'b0010;
        expect_frame(1, 16'hC3E7);
        wait_start("t5");
        repeat (2) @(negedge clock);
        req = 4'b0000;
        wait_done("t5", 1'b0);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done != '0) got = 1'b1;
        end
        check("t5_no_extra_done", 64'(got), 64'd0);
        check("t5_idle", 64'(busy), 64'd0);

`ifdef SERIAL_ARB_TIMEOUT_EN
        // ---- 6: watchdog, transmitter never signals the end of the frame
        tx_stall = 1'b1;
        req = 4'b0100;
        wait_start("t6");
        req = 4'b0000;
        n = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            n++;
            if (done != '0) got = 1'b1;
            else if (n == 64) check("t6_terr_early", 64'(timeout_err), 64'd0);
        end
        check("t6_done_seen", 64'(got), 64'd1);
        check("t6_cycles", 64'(n), 64'd65);
        check("t6_done_vec", 64'(done), 64'h4);
        check("t6_terr", 64'(timeout_err), 64'd1);
        repeat (2) @(negedge clock);
        check("t6_idle", 64'(busy), 64'd0);
        check("t6_terr_sticky", 64'(timeout_err), 64'd1);
        tx_stall = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
